// File: rtl/sfifo_gen_if.sv
// Handshake/data bundle for sfifo_gen: slave is the FIFO side, master the user side.
interface sfifo_gen_if #(
  parameter int DWIDTH = 22,
  parameter int AWIDTH = 4
);
  logic              i_sclr;
  logic [DWIDTH-1:0] iv_data;
  logic              i_wrreq;
  logic              i_rdreq;
  logic [DWIDTH-1:0] ov_q;
  logic              o_full;
  logic              o_alfull;
  logic              o_empty;
  logic              o_alempty;
  logic [AWIDTH:0]   ov_usedw;
  logic              o_overflow;
  logic              o_underflow;
  logic [15:0]       ov_ovf_cnt;
  logic [15:0]       ov_udf_cnt;

  modport slave (
    input  i_sclr, iv_data, i_wrreq, i_rdreq,
    output ov_q, o_full, o_alfull, o_empty, o_alempty, ov_usedw,
           o_overflow, o_underflow, ov_ovf_cnt, ov_udf_cnt
  );

  modport master (
    output i_sclr, iv_data, i_wrreq, i_rdreq,
    input  ov_q, o_full, o_alfull, o_empty, o_alempty, ov_usedw,
           o_overflow, o_underflow, ov_ovf_cnt, ov_udf_cnt
  );
endinterface

// File: rtl/sfifo_gen.sv
// Single-clock FIFO over an inferred dual-port RAM, normal or show-head read mode, any depth.
// Define SFIFO_GEN_ERR_CNT_EN to build the saturating overflow/underflow counters.
module sfifo_gen #(
  parameter int SHOWHEAD = 1,
  parameter int DWIDTH   = 22,
  parameter int DEPTH    = 16,
  parameter int AWIDTH   = 4,
  parameter int ALFULL   = 1,
  parameter int ALEMPTY  = 2
) (
  input logic        i_clk,
  input logic        i_rst_n,
  sfifo_gen_if.slave bus
);

  localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   ALFULL_W  = (AWIDTH+1)'(DEPTH - ALFULL);
  localparam logic [AWIDTH:0]   ALEMPTY_W = (AWIDTH+1)'(ALEMPTY);
  localparam logic [AWIDTH-1:0] PTR_LAST  = AWIDTH'(DEPTH - 1);

  logic [DWIDTH-1:0] ram [DEPTH];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic [DWIDTH-1:0] q_q, q_d;
  logic              valid_q, valid_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              alfull_q, alfull_d;
  logic              alempty_q, alempty_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              wr_acc;
  logic              rd_acc;
  logic              fetch;
  logic              bypass;
  logic [AWIDTH:0]   behind;

  function automatic logic [AWIDTH-1:0] next_ptr(input logic [AWIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (wr_acc) ram[wr_ptr_q] <= bus.iv_data;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    usedw_d   = usedw_q;
    q_d       = q_q;
    valid_d   = valid_q;
    empty_d   = empty_q;
    fetch     = 1'b0;
    bypass    = 1'b0;
    behind    = '0;

    wr_acc = bus.i_wrreq && !full_q && !bus.i_sclr;
    rd_acc = bus.i_rdreq && !empty_q && !bus.i_sclr;

    if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
    if (wr_acc && !rd_acc)      usedw_d = usedw_q + 1'b1;
    else if (!wr_acc && rd_acc) usedw_d = usedw_q - 1'b1;

    if (SHOWHEAD != 0) begin
      behind = usedw_q - {{AWIDTH{1'b0}}, valid_q};
      fetch  = (behind != '0) && (!valid_q || rd_acc) && !bus.i_sclr;
      // Head consumed with nothing stored behind it: the incoming word becomes
      // the head directly, so a fill level of 1 still streams one word per cycle.
      bypass = (behind == '0) && rd_acc && wr_acc;
      if (fetch)       q_d = ram[rd_ptr_q];
      else if (bypass) q_d = bus.iv_data;
      if (fetch || bypass) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
        valid_d  = 1'b1;
      end else if (rd_acc) begin
        valid_d  = 1'b0;
      end
      empty_d = !valid_d;
    end else begin
      if (rd_acc) begin
        q_d      = ram[rd_ptr_q];
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      empty_d = (usedw_d == '0);
    end

    full_d    = (usedw_d == DEPTH_W);
    alfull_d  = (usedw_d >= ALFULL_W);
    alempty_d = (usedw_d <= ALEMPTY_W);
    ovf_d     = bus.i_wrreq && full_q;
    udf_d     = bus.i_rdreq && empty_q;

    if (bus.i_sclr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      usedw_d   = '0;
      q_d       = '0;
      valid_d   = 1'b0;
      empty_d   = 1'b1;
      full_d    = 1'b0;
      alfull_d  = 1'b0;
      alempty_d = 1'b1;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usedw_q   <= '0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      alfull_q  <= 1'b0;
      alempty_q <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usedw_q   <= usedw_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      alfull_q  <= alfull_d;
      alempty_q <= alempty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

`ifdef SFIFO_GEN_ERR_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic [15:0] udf_cnt_q, udf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    udf_cnt_d = udf_cnt_q;
    if (ovf_q && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 1'b1;
    if (udf_q && (udf_cnt_q != '1)) udf_cnt_d = udf_cnt_q + 1'b1;
  end

  // Counters survive i_sclr; only the async reset clears them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      udf_cnt_q <= udf_cnt_d;
    end
  end

  assign bus.ov_ovf_cnt = ovf_cnt_q;
  assign bus.ov_udf_cnt = udf_cnt_q;
`else
  assign bus.ov_ovf_cnt = '0;
  assign bus.ov_udf_cnt = '0;
`endif

  assign bus.ov_q        = q_q;
  assign bus.o_full      = full_q;
  assign bus.o_alfull    = alfull_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_alempty   = alempty_q;
  assign bus.ov_usedw    = usedw_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;

endmodule

// File: tb/tb_sfifo_gen.sv
// Scoreboard bench for sfifo_gen: normal depth-16, show-head depth-16 and show-head depth-5 instances.
module tb_sfifo_gen;

`ifdef SFIFO_GEN_ERR_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sclr_i    [3];
  logic        wr_i      [3];
  logic        rd_i      [3];
  logic [21:0] data_i    [3];
  logic [21:0] q_o       [3];
  logic [4:0]  uw_o      [3];
  logic        full_o    [3];
  logic        alfull_o  [3];
  logic        empty_o   [3];
  logic        alempty_o [3];
  logic        ovf_o     [3];
  logic        udf_o     [3];
  logic [15:0] ovc_o     [3];
  logic [15:0] udc_o     [3];

  sfifo_gen_if #(.DWIDTH(22), .AWIDTH(4)) if_n16 ();
  sfifo_gen_if #(.DWIDTH(22), .AWIDTH(4)) if_s16 ();
  sfifo_gen_if #(.DWIDTH(22), .AWIDTH(3)) if_s5  ();

  sfifo_gen #(.SHOWHEAD(0), .DWIDTH(22), .DEPTH(16), .AWIDTH(4), .ALFULL(1), .ALEMPTY(2))
    u_n16 (.i_clk(clk), .i_rst_n(rst_n), .bus(if_n16));
  sfifo_gen #(.SHOWHEAD(1), .DWIDTH(22), .DEPTH(16), .AWIDTH(4), .ALFULL(1), .ALEMPTY(2))
    u_s16 (.i_clk(clk), .i_rst_n(rst_n), .bus(if_s16));
  sfifo_gen #(.SHOWHEAD(1), .DWIDTH(22), .DEPTH(5), .AWIDTH(3), .ALFULL(1), .ALEMPTY(2))
    u_s5  (.i_clk(clk), .i_rst_n(rst_n), .bus(if_s5));

  assign if_n16.i_sclr  = sclr_i[0];
  assign if_n16.i_wrreq = wr_i[0];
  assign if_n16.i_rdreq = rd_i[0];
  assign if_n16.iv_data = data_i[0];
  assign q_o[0]       = if_n16.ov_q;
  assign uw_o[0]      = if_n16.ov_usedw;
  assign full_o[0]    = if_n16.o_full;
  assign alfull_o[0]  = if_n16.o_alfull;
  assign empty_o[0]   = if_n16.o_empty;
  assign alempty_o[0] = if_n16.o_alempty;
  assign ovf_o[0]     = if_n16.o_overflow;
  assign udf_o[0]     = if_n16.o_underflow;
  assign ovc_o[0]     = if_n16.ov_ovf_cnt;
  assign udc_o[0]     = if_n16.ov_udf_cnt;

  assign if_s16.i_sclr  = sclr_i[1];
  assign if_s16.i_wrreq = wr_i[1];
  assign if_s16.i_rdreq = rd_i[1];
  assign if_s16.iv_data = data_i[1];
  assign q_o[1]       = if_s16.ov_q;
  assign uw_o[1]      = if_s16.ov_usedw;
  assign full_o[1]    = if_s16.o_full;
  assign alfull_o[1]  = if_s16.o_alfull;
  assign empty_o[1]   = if_s16.o_empty;
  assign alempty_o[1] = if_s16.o_alempty;
  assign ovf_o[1]     = if_s16.o_overflow;
  assign udf_o[1]     = if_s16.o_underflow;
  assign ovc_o[1]     = if_s16.ov_ovf_cnt;
  assign udc_o[1]     = if_s16.ov_udf_cnt;

  assign if_s5.i_sclr  = sclr_i[2];
  assign if_s5.i_wrreq = wr_i[2];
  assign if_s5.i_rdreq = rd_i[2];
  assign if_s5.iv_data = data_i[2];
  assign q_o[2]       = if_s5.ov_q;
  assign uw_o[2]      = {1'b0, if_s5.ov_usedw};
  assign full_o[2]    = if_s5.o_full;
  assign alfull_o[2]  = if_s5.o_alfull;
  assign empty_o[2]   = if_s5.o_empty;
  assign alempty_o[2] = if_s5.o_alempty;
  assign ovf_o[2]     = if_s5.o_overflow;
  assign udf_o[2]     = if_s5.o_underflow;
  assign ovc_o[2]     = if_s5.ov_ovf_cnt;
  assign udc_o[2]     = if_s5.ov_udf_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  logic [21:0] sb [$];
  logic [21:0] exp_w;
  logic [21:0] nxt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus on unit u; outputs are sampled 1 ns after the edge.
  task automatic tick(input int u, input logic s, input logic w, input logic r, input logic [21:0] d);
    sclr_i[u] = s;
    wr_i[u]   = w;
    rd_i[u]   = r;
    data_i[u] = d;
    @(posedge clk);
    #1;
    sclr_i[u] = 1'b0;
    wr_i[u]   = 1'b0;
    rd_i[u]   = 1'b0;
  endtask

  task automatic check_reset_all(input string pfx, input logic with_cnt);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("%s_q%0d", pfx, u),       32'(q_o[u]), 0);
      check($sformatf("%s_usedw%0d", pfx, u),   32'(uw_o[u]), 0);
      check($sformatf("%s_empty%0d", pfx, u),   32'(empty_o[u]), 1);
      check($sformatf("%s_alempty%0d", pfx, u), 32'(alempty_o[u]), 1);
      check($sformatf("%s_full%0d", pfx, u),    32'(full_o[u]), 0);
      check($sformatf("%s_alfull%0d", pfx, u),  32'(alfull_o[u]), 0);
      check($sformatf("%s_ovf%0d", pfx, u),     32'(ovf_o[u]), 0);
      check($sformatf("%s_udf%0d", pfx, u),     32'(udf_o[u]), 0);
      if (with_cnt) begin
        check($sformatf("%s_ovc%0d", pfx, u), 32'(ovc_o[u]), 0);
        check($sformatf("%s_udc%0d", pfx, u), 32'(udc_o[u]), 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      sclr_i[u] = 1'b0;
      wr_i[u]   = 1'b0;
      rd_i[u]   = 1'b0;
      data_i[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_all("rst", 1'b1);

    // Normal mode, depth 16: fill, overflow, drain in order.
    for (int k = 1; k <= 16; k++) begin
      tick(0, 1'b0, 1'b1, 1'b0, 22'(k));
      sb.push_back(22'(k));
      check("n16_wr_usedw", 32'(uw_o[0]), k);
      check("n16_wr_alfull", 32'(alfull_o[0]), 32'(k >= 15));
      check("n16_wr_full", 32'(full_o[0]), 32'(k == 16));
      check("n16_wr_empty", 32'(empty_o[0]), 0);
    end
    tick(0, 1'b0, 1'b1, 1'b0, 22'h99);
    check("n16_ovf_pulse", 32'(ovf_o[0]), 1);
    check("n16_ovf_usedw", 32'(uw_o[0]), 16);
    tick(0, 1'b0, 1'b0, 1'b0, 22'h0);
    check("n16_ovf_end", 32'(ovf_o[0]), 0);
    for (int i = 0; i < 16; i++) begin
      tick(0, 1'b0, 1'b0, 1'b1, 22'h0);
      exp_w = sb.pop_front();
      check("n16_rd_q", 32'(q_o[0]), 32'(exp_w));
      check("n16_rd_usedw", 32'(uw_o[0]), 15 - i);
      check("n16_rd_alempty", 32'(alempty_o[0]), 32'((15 - i) <= 2));
      check("n16_rd_full", 32'(full_o[0]), 0);
    end
    check("n16_drained_empty", 32'(empty_o[0]), 1);

    // Read on empty: underflow pulses, ov_q holds.
    for (int i = 0; i < 3; i++) begin
      tick(0, 1'b0, 1'b0, 1'b1, 22'h0);
      check("n16_udf_pulse", 32'(udf_o[0]), 1);
      check("n16_udf_qhold", 32'(q_o[0]), 32'h10);
    end
    tick(0, 1'b0, 1'b0, 1'b0, 22'h0);
    check("n16_udf_end", 32'(udf_o[0]), 0);
    check("n16_udf_cnt", 32'(udc_o[0]), (CNT_EN != 0) ? 3 : 0);
    check("n16_ovf_cnt", 32'(ovc_o[0]), (CNT_EN != 0) ? 1 : 0);

    // Synchronous clear beats simultaneous write/read.
    for (int k = 0; k < 10; k++) tick(0, 1'b0, 1'b1, 1'b0, 22'h200 + 22'(k));
    check("n16_fill10", 32'(uw_o[0]), 10);
    tick(0, 1'b1, 1'b1, 1'b1, 22'h3FFFFF);
    check("n16_sclr_usedw", 32'(uw_o[0]), 0);
    check("n16_sclr_empty", 32'(empty_o[0]), 1);
    check("n16_sclr_q", 32'(q_o[0]), 0);
    check("n16_sclr_alempty", 32'(alempty_o[0]), 1);
    check("n16_sclr_ovf", 32'(ovf_o[0]), 0);
    check("n16_sclr_udf", 32'(udf_o[0]), 0);
    tick(0, 1'b1, 1'b1, 1'b1, 22'h3FFFFF);
    check("n16_sclr_empty_udf", 32'(udf_o[0]), 0);
    check("n16_sclr_empty_usedw", 32'(uw_o[0]), 0);
    check("n16_sclr_udc_hold", 32'(udc_o[0]), (CNT_EN != 0) ? 3 : 0);
    check("n16_sclr_ovc_hold", 32'(ovc_o[0]), (CNT_EN != 0) ? 1 : 0);
    tick(0, 1'b0, 1'b1, 1'b0, 22'h123);
    tick(0, 1'b0, 1'b0, 1'b1, 22'h0);
    check("n16_post_sclr_q", 32'(q_o[0]), 32'h123);

    // Show-head, depth 16: two-cycle fall-through, then bubble-free burst.
    tick(1, 1'b0, 1'b1, 1'b0, 22'h2A);
    check("s16_wr_usedw", 32'(uw_o[1]), 1);
    check("s16_wr_empty", 32'(empty_o[1]), 1);
    tick(1, 1'b0, 1'b0, 1'b0, 22'h0);
    check("s16_ft_empty", 32'(empty_o[1]), 0);
    check("s16_ft_q", 32'(q_o[1]), 32'h2A);
    tick(1, 1'b0, 1'b0, 1'b1, 22'h0);
    check("s16_rd_empty", 32'(empty_o[1]), 1);
    check("s16_rd_usedw", 32'(uw_o[1]), 0);
    check("s16_rd_udf", 32'(udf_o[1]), 0);
    for (int k = 0; k < 6; k++) begin
      tick(1, 1'b0, 1'b1, 1'b0, 22'h100 + 22'(k));
      sb.push_back(22'h100 + 22'(k));
    end
    tick(1, 1'b0, 1'b0, 1'b0, 22'h0);
    for (int i = 0; i < 6; i++) begin
      check("s16_head_q", 32'(q_o[1]), 32'(sb[0]));
      check("s16_head_empty", 32'(empty_o[1]), 0);
      tick(1, 1'b0, 1'b0, 1'b1, 22'h0);
      exp_w = sb.pop_front();
    end
    check("s16_burst_empty", 32'(empty_o[1]), 1);
    check("s16_burst_usedw", 32'(uw_o[1]), 0);

    // Show-head, depth 5: streaming at fill 3 across many pointer wraps.
    nxt = 22'h1;
    for (int k = 0; k < 3; k++) begin
      tick(2, 1'b0, 1'b1, 1'b0, nxt);
      sb.push_back(nxt);
      nxt = nxt + 22'h1;
    end
    tick(2, 1'b0, 1'b0, 1'b0, 22'h0);
    for (int i = 0; i < 40; i++) begin
      check("s5_head_q", 32'(q_o[2]), 32'(sb[0]));
      check("s5_head_empty", 32'(empty_o[2]), 0);
      tick(2, 1'b0, 1'b1, 1'b1, nxt);
      sb.push_back(nxt);
      nxt = nxt + 22'h1;
      exp_w = sb.pop_front();
      check("s5_usedw", 32'(uw_o[2]), 3);
      check("s5_alfull", 32'(alfull_o[2]), 0);
      check("s5_ovf", 32'(ovf_o[2]), 0);
      check("s5_udf", 32'(udf_o[2]), 0);
    end
    for (int i = 0; i < 3; i++) begin
      check("s5_drain_q", 32'(q_o[2]), 32'(sb[0]));
      tick(2, 1'b0, 1'b0, 1'b1, 22'h0);
      exp_w = sb.pop_front();
    end
    check("s5_drain_empty", 32'(empty_o[2]), 1);
    check("s5_drain_usedw", 32'(uw_o[2]), 0);

    // Show-head streaming at fill level 1.
    tick(2, 1'b0, 1'b1, 1'b0, nxt);
    sb.push_back(nxt);
    nxt = nxt + 22'h1;
    tick(2, 1'b0, 1'b0, 1'b0, 22'h0);
    for (int i = 0; i < 4; i++) begin
      check("s5_f1_q", 32'(q_o[2]), 32'(sb[0]));
      check("s5_f1_empty", 32'(empty_o[2]), 0);
      tick(2, 1'b0, 1'b1, 1'b1, nxt);
      sb.push_back(nxt);
      nxt = nxt + 22'h1;
      exp_w = sb.pop_front();
      check("s5_f1_usedw", 32'(uw_o[2]), 1);
    end
    check("s5_f1_last_q", 32'(q_o[2]), 32'(sb[0]));
    tick(2, 1'b0, 1'b0, 1'b1, 22'h0);
    exp_w = sb.pop_front();
    check("s5_f1_end_empty", 32'(empty_o[2]), 1);

    // Asynchronous reset in the middle of a show-head burst.
    for (int k = 0; k < 4; k++) tick(1, 1'b0, 1'b1, 1'b0, 22'h300 + 22'(k));
    check("s16_pre_rst_usedw", 32'(uw_o[1]), 4);
    wr_i[1]   = 1'b1;
    rd_i[1]   = 1'b1;
    data_i[1] = 22'h3AB;
    #2 rst_n = 1'b0;
    #1;
    check_reset_all("arst", 1'b1);
    wr_i[1] = 1'b0;
    rd_i[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1, 1'b0, 1'b1, 1'b0, 22'h55);
    tick(1, 1'b0, 1'b0, 1'b0, 22'h0);
    check("s16_post_rst_q", 32'(q_o[1]), 32'h55);
    check("s16_post_rst_empty", 32'(empty_o[1]), 0);
    check("s16_post_rst_usedw", 32'(uw_o[1]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
